// File: rtl/mem_bus_master_pkg.sv
// mem_bus_master_pkg: memory-map region codes, FSM state encoding and byte-lane codes
// shared by the bus master and its lane steering logic.
package mem_bus_master_pkg;
    localparam logic [2:0] ROM_REGION       = 3'b000;
    localparam logic [2:0] MAP_LIMIT_REGION = 3'b011;
    localparam logic       LANE_LO          = 1'b0;
    localparam logic       LANE_HI          = 1'b1;
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_STROBE = 2'd2,
        S_HOLD   = 2'd3
    } state_t;
endpackage

// File: rtl/mem_lane_steer.sv
// mem_lane_steer: byte-lane steering -- write data replication, lane strobe mask
// and zero-extended read byte extraction.
module mem_lane_steer
    import mem_bus_master_pkg::*;
(
    input  logic        byte_en,
    input  logic        bsel,
    input  logic [15:0] wdata,
    input  logic [15:0] din,
    output logic [15:0] wdata_out,
    output logic [1:0]  lane_mask,
    output logic [15:0] rdata_out
);
    always_comb begin
        wdata_out = byte_en ? {2{wdata[7:0]}} : wdata;
        lane_mask = byte_en ? {bsel == LANE_HI, bsel == LANE_LO} : 2'b11;
        rdata_out = byte_en ? {8'h00, (bsel == LANE_HI) ? din[15:8] : din[7:0]} : din;
    end
endmodule

// File: rtl/mem_bus_master.sv
// mem_bus_master: turns a single-cycle CPU request into a SETUP/STROBE/HOLD memory bus
// cycle with programmable wait states, ROM write suppression and unmapped-access faults.
module mem_bus_master
    import mem_bus_master_pkg::*;
#(
    parameter int unsigned WAIT_STATES = 1,
    parameter logic [2:0]  ROM_TOP     = ROM_REGION,
    parameter logic [2:0]  MAP_LIMIT   = MAP_LIMIT_REGION
) (
    input  logic        CLK,
    input  logic        RESETN,
    input  logic        REQ,
    input  logic        WE,
    input  logic        BYTE,
    input  logic        BSEL,
    input  logic [15:0] CPU_ADDR,
    input  logic [15:0] WDATA,
    output logic [15:0] RDATA,
    output logic        BUSY,
    output logic        DONE,
    output logic        FAULT,
    output logic [15:0] ADDR,
    output logic [15:0] DOUT,
    input  logic [15:0] DIN,
    output logic        RDN,
    output logic        WR0N,
    output logic        WR1N
);
    if (WAIT_STATES > 15) begin : g_ws_range
        $error("mem_bus_master: WAIT_STATES must fit the 4-bit wait counter");
    end

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d, byte_q, byte_d, bsel_q, bsel_d;
    logic [15:0] addr_q, addr_d, dout_q, dout_d, rdata_q, rdata_d;
    logic        rdn_q, rdn_d, wr0n_q, wr0n_d, wr1n_q, wr1n_d;
    logic        busy_q, busy_d, done_q, done_d, fault_q, fault_d;
    logic [15:0] steer_wdata, steer_rdata;
    logic [1:0]  lane_mask;
    logic        unmapped, suppress;

    // In IDLE the steer sees the live request so DOUT can be replicated at acceptance;
    // afterwards it sees the latched access attributes.
    mem_lane_steer u_steer (
        .byte_en   (state_q == S_IDLE ? BYTE : byte_q),
        .bsel      (state_q == S_IDLE ? BSEL : bsel_q),
        .wdata     (WDATA),
        .din       (DIN),
        .wdata_out (steer_wdata),
        .lane_mask (lane_mask),
        .rdata_out (steer_rdata)
    );

    assign unmapped = addr_q[15:13] > MAP_LIMIT;
    assign suppress = we_q && (addr_q[15:13] == ROM_TOP || unmapped);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        byte_d  = byte_q;
        bsel_d  = bsel_q;
        addr_d  = addr_q;
        dout_d  = dout_q;
        rdata_d = rdata_q;
        rdn_d   = rdn_q;
        wr0n_d  = wr0n_q;
        wr1n_d  = wr1n_q;
        done_d  = 1'b0;
        fault_d = 1'b0;
        case (state_q)
            S_IDLE: if (REQ) begin
                we_d    = WE;
                byte_d  = BYTE;
                bsel_d  = BSEL;
                addr_d  = CPU_ADDR;
                dout_d  = steer_wdata;
                state_d = S_SETUP;
            end
            S_SETUP: begin
                state_d = S_STROBE;
                cnt_d   = 4'(WAIT_STATES);
                rdn_d   = we_q;
                wr0n_d  = !(we_q && !suppress && lane_mask[0]);
                wr1n_d  = !(we_q && !suppress && lane_mask[1]);
            end
            S_STROBE: if (cnt_q == 4'd0) begin
                state_d = S_HOLD;
                rdn_d   = 1'b1;
                wr0n_d  = 1'b1;
                wr1n_d  = 1'b1;
                done_d  = 1'b1;
                fault_d = suppress || unmapped;
                rdata_d = we_q ? rdata_q : steer_rdata;
            end else begin
                cnt_d = cnt_q - 4'd1;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = state_d != S_IDLE;
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            byte_q  <= 1'b0;
            bsel_q  <= 1'b0;
            addr_q  <= '0;
            dout_q  <= '0;
            rdata_q <= '0;
            rdn_q   <= 1'b1;
            wr0n_q  <= 1'b1;
            wr1n_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            byte_q  <= byte_d;
            bsel_q  <= bsel_d;
            addr_q  <= addr_d;
            dout_q  <= dout_d;
            rdata_q <= rdata_d;
            rdn_q   <= rdn_d;
            wr0n_q  <= wr0n_d;
            wr1n_q  <= wr1n_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            fault_q <= fault_d;
        end
    end

    assign RDATA = rdata_q;
    assign BUSY  = busy_q;
    assign DONE  = done_q;
    assign FAULT = fault_q;
    assign ADDR  = addr_q;
    assign DOUT  = dout_q;
    assign RDN   = rdn_q;
    assign WR0N  = wr0n_q;
    assign WR1N  = wr1n_q;
endmodule

// File: tb/tb_mem_bus_master.sv
// tb_mem_bus_master: directed vector table for mem_bus_master (WAIT_STATES=1) plus
// hand sequences for back-to-back requests (WAIT_STATES=0), ignored REQ and mid-cycle reset.
module tb_mem_bus_master;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0, req0 = 1'b0;
    logic        we = 1'b0, byte_in = 1'b0, bsel_in = 1'b0;
    logic [15:0] cpu_addr = '0, wdata = '0, din = '0;
    logic [15:0] rdata, addr, dout, rdata0, addr0, dout0;
    logic        busy, done, fault, rdn, wr0n, wr1n;
    logic        busy0, done0, fault0, rdn0, wr0n0, wr1n0;
    int          n_vec = 0, n_err = 0;

    typedef struct {
        logic        we, byte_acc, bsel;
        logic [15:0] addr, wdata, din, exp_rdata, exp_dout;
        logic        exp_fault;
        int          exp_rd, exp_w0, exp_w1;
    } vec_t;
    vec_t vecs[11];

    always #5 clk = ~clk;

    mem_bus_master dut (
        .CLK(clk), .RESETN(rst_n), .REQ(req), .WE(we), .BYTE(byte_in), .BSEL(bsel_in),
        .CPU_ADDR(cpu_addr), .WDATA(wdata), .RDATA(rdata), .BUSY(busy), .DONE(done),
        .FAULT(fault), .ADDR(addr), .DOUT(dout), .DIN(din), .RDN(rdn), .WR0N(wr0n), .WR1N(wr1n)
    );

    mem_bus_master #(.WAIT_STATES(0)) dut0 (
        .CLK(clk), .RESETN(rst_n), .REQ(req0), .WE(we), .BYTE(byte_in), .BSEL(bsel_in),
        .CPU_ADDR(cpu_addr), .WDATA(wdata), .RDATA(rdata0), .BUSY(busy0), .DONE(done0),
        .FAULT(fault0), .ADDR(addr0), .DOUT(dout0), .DIN(din), .RDN(rdn0), .WR0N(wr0n0), .WR1N(wr1n0)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_req(input vec_t v);
        we = v.we; byte_in = v.byte_acc; bsel_in = v.bsel;
        cpu_addr = v.addr; wdata = v.wdata; din = v.din;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int rd_lo = 0, w0_lo = 0, w1_lo = 0, done_at = -1;
        logic fault_at_done = 1'b0, stray_fault = 1'b0, addr_ok = 1'b1, overlap = 1'b0;
        logic [5:0] busy_pat = '0;
        @(negedge clk);
        set_req(v);
        req = 1'b1;
        @(posedge clk);
        #1 req = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            rd_lo += int'(!rdn);
            w0_lo += int'(!wr0n);
            w1_lo += int'(!wr1n);
            if (!rdn && (!wr0n || !wr1n)) overlap = 1'b1;
            if (busy && addr !== v.addr) addr_ok = 1'b0;
            if (fault && !done) stray_fault = 1'b1;
            if (done) begin
                done_at = (done_at < 0) ? k : 99;
                fault_at_done = fault;
            end
            busy_pat[k] = busy;
        end
        chk($sformatf("v%0d done_at", idx), done_at, 3);
        chk($sformatf("v%0d fault", idx), {31'd0, fault_at_done}, {31'd0, v.exp_fault});
        chk($sformatf("v%0d rdata", idx), {16'd0, rdata}, {16'd0, v.exp_rdata});
        chk($sformatf("v%0d dout", idx), {16'd0, dout}, {16'd0, v.exp_dout});
        chk($sformatf("v%0d rdn_low", idx), rd_lo, v.exp_rd);
        chk($sformatf("v%0d wr0n_low", idx), w0_lo, v.exp_w0);
        chk($sformatf("v%0d wr1n_low", idx), w1_lo, v.exp_w1);
        chk($sformatf("v%0d busy_pattern", idx), {26'd0, busy_pat}, {26'd0, 6'b001111});
        chk($sformatf("v%0d addr_stable", idx), {31'd0, addr_ok}, 1);
        chk($sformatf("v%0d strobe_overlap/stray_fault", idx), {30'd0, overlap, stray_fault}, 0);
    endtask

    initial begin
        //           we    byte  bsel  addr      wdata     din       rdata     dout      flt   rd w0 w1
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 16'h2004, 16'h0000, 16'hBEEF, 16'hBEEF, 16'h0000, 1'b0, 2, 0, 0};
        vecs[1]  = '{1'b1, 1'b1, 1'b1, 16'h3000, 16'h00A5, 16'h0000, 16'hBEEF, 16'hA5A5, 1'b0, 0, 0, 2};
        vecs[2]  = '{1'b0, 1'b1, 1'b1, 16'h2010, 16'h0000, 16'h12F0, 16'h0012, 16'h0000, 1'b0, 2, 0, 0};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 16'h2010, 16'h0000, 16'h12F0, 16'h00F0, 16'h0000, 1'b0, 2, 0, 0};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 16'h0100, 16'h1234, 16'h0000, 16'h00F0, 16'h1234, 1'b1, 0, 0, 0};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 16'h8000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b1, 2, 0, 0};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 16'h4000, 16'hCAFE, 16'h0000, 16'h0000, 16'hCAFE, 1'b0, 0, 2, 2};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 16'h6002, 16'h1234, 16'h0000, 16'h0000, 16'h3434, 1'b0, 0, 2, 0};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 16'hA000, 16'h5555, 16'h0000, 16'h0000, 16'h5555, 1'b1, 0, 0, 0};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 16'h7FFE, 16'h0000, 16'h5A5A, 16'h5A5A, 16'h0000, 1'b0, 2, 0, 0};
        vecs[10] = '{1'b0, 1'b1, 1'b1, 16'hE000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b1, 2, 0, 0};

        repeat (2) @(negedge clk);
        chk("reset addr/dout", {addr, dout}, 32'h0);
        chk("reset rdata", {16'd0, rdata}, 32'h0);
        chk("reset strobes", {29'd0, rdn, wr0n, wr1n}, 32'h7);
        chk("reset busy/done/fault", {29'd0, busy, done, fault}, 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);

        // REQ held high on the zero-wait-state instance: a new cycle every 4 clocks
        @(negedge clk);
        set_req(vecs[0]);
        req0 = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            chk($sformatf("held k%0d busy/done/rdn", k), {29'd0, busy0, done0, rdn0},
                {29'd0, (k % 4) != 3, (k % 4) == 2, (k % 4) != 1});
        end
        req0 = 1'b0;
        repeat (4) @(negedge clk);
        chk("held rdata", {16'd0, rdata0}, {16'd0, 16'hBEEF});

        // REQ pulses while busy must not start another cycle
        begin
            int dones = 0;
            set_req(vecs[6]);
            req = 1'b1;
            @(posedge clk);
            #1 req = 1'b0;
            for (int k = 0; k < 6; k++) begin
                @(negedge clk);
                dones += int'(done);
                if (k == 4 || k == 5) chk($sformatf("ignore k%0d busy", k), {31'd0, busy}, 0);
                req = (k < 4) ? (k % 2 == 0) || (k == 3) : 1'b0;
            end
            chk("ignore done count", dones, 1);
        end

        // reset asserted during STROBE of a word write
        @(negedge clk);
        set_req(vecs[6]);
        req = 1'b1;
        @(posedge clk);
        #1 req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mid-reset strobe active", {30'd0, wr0n, wr1n}, 0);
        rst_n = 1'b0;
        #1;
        chk("mid-reset strobes released", {29'd0, rdn, wr0n, wr1n}, 32'h7);
        chk("mid-reset addr/dout", {addr, dout}, 32'h0);
        chk("mid-reset busy/done/fault", {29'd0, busy, done, fault}, 0);
        begin
            logic saw_done = 1'b0;
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                saw_done |= done;
            end
            chk("mid-reset no done", {31'd0, saw_done}, 0);
        end
        rst_n = 1'b1;
        run_vec(99, vecs[0]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
